// File: rtl/csi2_pkt_handler.sv
// CSI-2 packet parser for the D-PHY slave word stream.
// Checks the header ECC, turns short packets into sync pulses and
// forwards long-packet payload as byte-enabled words with the CRC removed.
module csi2_pkt_handler #(
   parameter logic ECC_CHECK = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        enable_i,
   input  logic [31:0] data_i,
   input  logic        valid_i,
   output logic        pkt_done_o,
   output logic [31:0] payload_data_o,
   output logic [3:0]  payload_be_o,
   output logic        payload_valid_o,
   output logic        payload_last_o,
   output logic [5:0]  payload_dt_o,
   output logic [1:0]  payload_vc_o,
   output logic        frame_start_o,
   output logic        frame_end_o,
   output logic        line_start_o,
   output logic        line_end_o,
   output logic [15:0] short_data_o,
   output logic        ecc_err_o
);

   localparam logic ST_HEADER = 1'b0;
   localparam logic ST_BODY   = 1'b1;

   // Each ECC bit is the parity of the header bits selected by its mask;
   // the two top ECC bits are always zero.
   function automatic logic [7:0] ecc_calc(input logic [23:0] h);
      ecc_calc = {2'b00,
                  ^(h & 24'hEFFC00), ^(h & 24'hDF03F0), ^(h & 24'hB8E38E),
                  ^(h & 24'h749A6D), ^(h & 24'hF2555B), ^(h & 24'hF12CB7)};
   endfunction

   logic        state;
   logic [16:0] rem;

   logic        ecc_bad;
   logic [16:0] pay_left;
   logic [2:0]  nbytes;
   logic [3:0]  be_calc;
   logic        last_calc;
   logic [16:0] rem_next;

   // Header check and body byte accounting for the word currently on data_i.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      be_calc   = 4'h0;
      ecc_bad   = (data_i[31:24] != ecc_calc(data_i[23:0]));
      pay_left  = (rem > 17'd2) ? (rem - 17'd2) : 17'd0;
      nbytes    = (pay_left >= 17'd4) ? 3'd4 : pay_left[2:0];
      case (nbytes)
         3'd1:    be_calc = 4'h1;
         3'd2:    be_calc = 4'h3;
         3'd3:    be_calc = 4'h7;
         3'd4:    be_calc = 4'hF;
         default: be_calc = 4'h0;
      endcase
      last_calc = ((rem - {14'd0, nbytes}) == 17'd2);
      rem_next  = (rem > 17'd4) ? (rem - 17'd4) : 17'd0;
   end

   // Parser state, remaining byte count and all registered outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state           <= ST_HEADER;
         rem             <= 17'd0;
         pkt_done_o      <= 1'b0;
         payload_data_o  <= 32'd0;
         payload_be_o    <= 4'd0;
         payload_valid_o <= 1'b0;
         payload_last_o  <= 1'b0;
         payload_dt_o    <= 6'd0;
         payload_vc_o    <= 2'd0;
         frame_start_o   <= 1'b0;
         frame_end_o     <= 1'b0;
         line_start_o    <= 1'b0;
         line_end_o      <= 1'b0;
         short_data_o    <= 16'd0;
         ecc_err_o       <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         pkt_done_o      <= 1'b0;
         payload_valid_o <= 1'b0;
         payload_last_o  <= 1'b0;
         frame_start_o   <= 1'b0;
         frame_end_o     <= 1'b0;
         line_start_o    <= 1'b0;
         line_end_o      <= 1'b0;
         ecc_err_o       <= 1'b0;

         if (!enable_i) begin
            state <= ST_HEADER;
            rem   <= 17'd0;
         end else if (valid_i) begin
            if (state == ST_HEADER) begin
               if (ECC_CHECK && ecc_bad) begin
                  ecc_err_o  <= 1'b1;
                  pkt_done_o <= 1'b1;
               end else if (data_i[5:0] <= 6'h0F) begin
                  case (data_i[5:0])
                     6'h00:   frame_start_o <= 1'b1;
                     6'h01:   frame_end_o   <= 1'b1;
                     6'h02:   line_start_o  <= 1'b1;
                     6'h03:   line_end_o    <= 1'b1;
                     default: ;
                  endcase
                  short_data_o <= data_i[23:8];
                  pkt_done_o   <= 1'b1;
               end else begin
                  payload_dt_o <= data_i[5:0];
                  payload_vc_o <= data_i[7:6];
                  rem          <= {1'b0, data_i[23:8]} + 17'd2;
                  state        <= ST_BODY;
               end
            end else begin
               if (nbytes != 3'd0) begin
                  payload_valid_o <= 1'b1;
                  payload_data_o  <= data_i;
                  payload_be_o    <= be_calc;
                  payload_last_o  <= last_calc;
               end
               rem <= rem_next;
               if (rem_next == 17'd0) begin
                  pkt_done_o <= 1'b1;
                  state      <= ST_HEADER;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_csi2_pkt_handler.sv
// Self-checking bench for csi2_pkt_handler: directed packets from the test
// plan plus a randomized packet stream, checked word by word against a
// byte-position model of each packet.
module tb_csi2_pkt_handler;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        enable_i;
   logic [31:0] data_i;
   logic        valid_i;
   logic        pkt_done_o;
   logic [31:0] payload_data_o;
   logic [3:0]  payload_be_o;
   logic        payload_valid_o;
   logic        payload_last_o;
   logic [5:0]  payload_dt_o;
   logic [1:0]  payload_vc_o;
   logic        frame_start_o;
   logic        frame_end_o;
   logic        line_start_o;
   logic        line_end_o;
   logic [15:0] short_data_o;
   logic        ecc_err_o;

   int checks   = 0;
   int failures = 0;

   logic [15:0] exp_short = 16'd0;
   logic [7:0]  pay_bytes [0:63];

   // ECC syndrome column for each header data bit (D0..D23).
   localparam logic [5:0] ECC_COL [24] = '{
      6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
      6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
      6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

   csi2_pkt_handler dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .enable_i(enable_i),
      .data_i(data_i), .valid_i(valid_i), .pkt_done_o(pkt_done_o),
      .payload_data_o(payload_data_o), .payload_be_o(payload_be_o),
      .payload_valid_o(payload_valid_o), .payload_last_o(payload_last_o),
      .payload_dt_o(payload_dt_o), .payload_vc_o(payload_vc_o),
      .frame_start_o(frame_start_o), .frame_end_o(frame_end_o),
      .line_start_o(line_start_o), .line_end_o(line_end_o),
      .short_data_o(short_data_o), .ecc_err_o(ecc_err_o));

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] make_header(input logic [5:0] dt,
                                               input logic [1:0] vc,
                                               input int wc);
      logic [23:0] h;
      logic [5:0]  e;
      h = {wc[15:0], vc, dt};
      e = 6'd0;
      for (int i = 0; i < 24; i++)
         if (h[i]) e = e ^ ECC_COL[i];
      return {2'b00, e, h};
   endfunction

   function automatic logic [6:0] strobes();
      return {frame_start_o, frame_end_o, line_start_o, line_end_o,
              ecc_err_o, pkt_done_o, payload_valid_o};
   endfunction

   // Drives one packet (header plus body words, with 'gap' idle cycles
   // before each word) and checks the outputs after every sampled word.
   // flip >= 0 corrupts that header bit; such a packet is header-only.
   task automatic run_packet(input logic [5:0] dt, input logic [1:0] vc,
                             input int wc, input int gap, input int flip,
                             input bit use_pay, input string name);
      logic [31:0] hdr, word, mask;
      logic [7:0]  body [0:71];
      logic [6:0]  exp_st;
      bit          corrupt, is_short, beat, last;
      int          nb, start, nbytes;
      logic [3:0]  be;
      hdr = make_header(dt, vc, wc);
      corrupt = (flip >= 0);
      if (corrupt) hdr[flip] = ~hdr[flip];
      is_short = (dt <= 6'h0F);
      nb = (corrupt || is_short) ? 0 : (wc + 5) / 4;
      for (int i = 0; i < 72; i++) body[i] = 8'h00;
      for (int i = 0; i < wc && i < 64; i++) begin
         if (!use_pay) pay_bytes[i] = 8'($urandom);
         body[i] = pay_bytes[i];
      end
      if (nb > 0) begin
         body[wc]     = 8'($urandom);
         body[wc + 1] = 8'($urandom);
      end
      for (int k = 0; k <= nb; k++) begin
         for (int g = 0; g < gap; g++) begin
            valid_i = 1'b0;
            data_i  = $urandom;
            @(posedge clk_i); #1;
            checks++;
            if (strobes() !== 7'd0) begin
               failures++;
               $display("FAIL %s gap word%0d strobes got=%b want=0000000", name, k, strobes());
            end
         end
         if (k == 0) word = hdr;
         else for (int i = 0; i < 4; i++) word[8*i +: 8] = body[(k-1)*4 + i];
         valid_i = 1'b1;
         data_i  = word;
         @(posedge clk_i); #1;
         valid_i = 1'b0;
         beat = 1'b0; last = 1'b0; be = 4'h0; nbytes = 0;
         if (k == 0) begin
            if (corrupt) exp_st = 7'b0000110;
            else if (is_short) begin
               exp_st = {dt == 6'h00, dt == 6'h01, dt == 6'h02, dt == 6'h03, 3'b010};
               exp_short = wc[15:0];
            end else exp_st = 7'd0;
         end else begin
            start  = (k - 1) * 4;
            nbytes = (wc > start) ? ((wc - start > 4) ? 4 : wc - start) : 0;
            beat   = (nbytes > 0);
            last   = beat && (start + nbytes == wc);
            be     = 4'((1 << nbytes) - 1);
            exp_st = {4'b0000, 1'b0, k == nb, beat};
         end
         checks++;
         if (strobes() !== exp_st) begin
            failures++;
            $display("FAIL %s word%0d strobes{fs,fe,ls,le,ecc,done,valid} got=%b want=%b",
                     name, k, strobes(), exp_st);
         end
         checks++;
         if (short_data_o !== exp_short) begin
            failures++;
            $display("FAIL %s word%0d short_data got=%h want=%h", name, k, short_data_o, exp_short);
         end
         if (beat) begin
            mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            checks++;
            if ({payload_be_o, payload_last_o, payload_dt_o, payload_vc_o} !== {be, last, dt, vc}) begin
               failures++;
               $display("FAIL %s word%0d be/last/dt/vc got=%h/%b/%h/%h want=%h/%b/%h/%h", name, k,
                        payload_be_o, payload_last_o, payload_dt_o, payload_vc_o, be, last, dt, vc);
            end
            checks++;
            if ((payload_data_o & mask) !== (word & mask)) begin
               failures++;
               $display("FAIL %s word%0d payload_data got=%h want=%h", name, k,
                        payload_data_o & mask, word & mask);
            end
         end
      end
   endtask

   task automatic do_reset();
      rst_n_i = 1'b0;
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
      exp_short = 16'd0;
   endtask

   task automatic test_reset();
      enable_i = 1'b1; valid_i = 1'b0; data_i = 32'd0;
      do_reset();
      checks++;
      if ({strobes(), payload_data_o, payload_be_o, payload_last_o, payload_dt_o,
           payload_vc_o, short_data_o} !== '0) begin
         failures++;
         $display("FAIL reset_values got nonzero output data=%h be=%h dt=%h short=%h st=%b",
                  payload_data_o, payload_be_o, payload_dt_o, short_data_o, strobes());
      end
   endtask

   task automatic test_frame_start();
      run_packet(6'h00, 2'd0, 1, 0, -1, 1'b0, "frame_start");
   endtask

   task automatic test_raw10();
      pay_bytes[0] = 8'h11; pay_bytes[1] = 8'h22; pay_bytes[2] = 8'h33;
      pay_bytes[3] = 8'h44; pay_bytes[4] = 8'h55;
      run_packet(6'h2B, 2'd1, 5, 0, -1, 1'b1, "raw10_wc5");
   endtask

   task automatic test_wc_edges();
      run_packet(6'h2A, 2'd2, 4, 0, -1, 1'b0, "wc4");
      run_packet(6'h12, 2'd3, 0, 0, -1, 1'b0, "wc0");
      run_packet(6'h1E, 2'd0, 6, 0, -1, 1'b0, "wc6");
      run_packet(6'h2C, 2'd1, 7, 0, -1, 1'b0, "wc7");
   endtask

   task automatic test_ecc_error();
      run_packet(6'h00, 2'd0, 16'h1234, 0, 10, 1'b0, "ecc_bit10");
      run_packet(6'h01, 2'd0, 16'h0042, 0, -1, 1'b0, "after_ecc");
      run_packet(6'h2B, 2'd2, 9, 0, 30, 1'b0, "ecc_bit30");
      run_packet(6'h2B, 2'd2, 9, 0, -1, 1'b0, "after_ecc_long");
   endtask

   task automatic test_back_to_back();
      run_packet(6'h24, 2'd1, 8, 3, -1, 1'b0, "gaps_wc8");
      run_packet(6'h03, 2'd1, 16'h00A5, 0, -1, 1'b0, "line_end_b2b");
   endtask

   // Starts a WC=16 packet and sends one payload word, checking that beat.
   task automatic start_wc16(input string name);
      logic [31:0] w;
      valid_i = 1'b1;
      data_i  = make_header(6'h2B, 2'd0, 16);
      @(posedge clk_i); #1;
      w = $urandom;
      data_i = w;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      checks++;
      if ({payload_valid_o, payload_be_o, payload_data_o} !== {1'b1, 4'hF, w}) begin
         failures++;
         $display("FAIL %s first_beat got v=%b be=%h d=%h want v=1 be=f d=%h",
                  name, payload_valid_o, payload_be_o, payload_data_o, w);
      end
   endtask

   task automatic test_reset_mid_packet();
      start_wc16("reset_mid");
      #2 rst_n_i = 1'b0;
      #1;
      checks++;
      if ({strobes(), payload_data_o, payload_be_o, payload_last_o, payload_dt_o,
           payload_vc_o, short_data_o} !== '0) begin
         failures++;
         $display("FAIL reset_mid async_clear data=%h be=%h dt=%h short=%h st=%b",
                  payload_data_o, payload_be_o, payload_dt_o, short_data_o, strobes());
      end
      exp_short = 16'd0;
      @(posedge clk_i); #1;
      rst_n_i = 1'b1;
      run_packet(6'h00, 2'd0, 16'h0007, 0, -1, 1'b0, "after_reset");
   endtask

   task automatic test_enable_mid_packet();
      start_wc16("enable_mid");
      enable_i = 1'b0;
      valid_i  = 1'b1;
      data_i   = $urandom;
      @(posedge clk_i); #1;
      valid_i  = 1'b0;
      enable_i = 1'b1;
      checks++;
      if (strobes() !== 7'd0) begin
         failures++;
         $display("FAIL enable_low strobes got=%b want=0000000", strobes());
      end
      run_packet(6'h02, 2'd0, 16'h0BEE, 0, -1, 1'b0, "after_enable");
   endtask

   task automatic test_random();
      logic [5:0] dt;
      int wc, flip;
      for (int p = 0; p < 40; p++) begin
         dt   = 6'($urandom);
         wc   = $urandom_range(0, 40);
         flip = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : -1;
         run_packet(dt, 2'($urandom), wc, $urandom_range(0, 2), flip, 1'b0, "random");
      end
   endtask

   initial begin
      rst_n_i = 1'b0;
      test_reset();
      test_frame_start();
      test_raw10();
      test_wc_edges();
      test_ecc_error();
      test_back_to_back();
      test_reset_mid_packet();
      test_enable_mid_packet();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/csi2_pkt_handler.md
# csi2_pkt_handler

Parses the 32-bit word stream produced by the D-PHY slave (byte clock domain) into CSI-2 packets. It checks the header ECC, decodes short packets into sync pulses, and emits long-packet payload as a byte-enabled word stream with the CRC stripped. It drives the packet-done strobe back to the D-PHY word aligner so that the aligner re-arms for the next SoT sync.

## Interface
- ECC_CHECK, 1, 1 = drop packets whose header ECC mismatches; 0 = ignore ECC.
- clk_i  in  1  byte clock from the D-PHY slave; the only clock.
- rst_n_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  0 = parser held in HEADER state, all strobes low.
- data_i  in  32  mapped word; byte 0 in [7:0] is the first byte received.
- valid_i  in  1  data_i qualifier; gaps are allowed anywhere.
- pkt_done_o  out  1  one-cycle pulse: packet fully consumed, resync aligner.
- payload_data_o  out  32  payload word, byte 0 in [7:0].
- payload_be_o  out  4  byte enables, LSB-contiguous.
- payload_valid_o  out  1  payload beat qualifier.
- payload_last_o  out  1  final payload beat of the packet.
- payload_dt_o  out  6  data type of the current long packet.
- payload_vc_o  out  2  virtual channel of the current long packet.
- frame_start_o, frame_end_o, line_start_o, line_end_o  out  1 each  one-cycle pulses for DT 0x00–0x03.
- short_data_o  out  16  WC field of the last valid short packet.
- ecc_err_o  out  1  one-cycle pulse on ECC mismatch.

## Operation
- Header word: DI = [7:0] (VC = [7:6], DT = [5:0]); WC = [23:8]; ECC = [31:24].
- ECC: CSI-2 v1.x 6-bit Hamming code over header bits [23:0]; ECC bits [7:6] must be 0. The check is a compare only; there is no single-bit correction.
- State HEADER, on a valid word:
  - ECC mismatch and ECC_CHECK = 1 → ecc_err_o, pkt_done_o, stay in HEADER. No other output fires.
  - DT ≤ 0x0F (short packet) → pulse the matching sync strobe (DT 0x04–0x0F: no strobe), load short_data_o = WC, pkt_done_o, stay in HEADER.
  - Otherwise (long packet) → latch DT and VC, load rem = WC + 2 (17 bits), go to BODY.
- State BODY, on each valid word:
  - Payload bytes in the word: n = min(4, max(rem − 2, 0)).
  - n > 0 → emit a beat with be = (1 << n) − 1.
  - n = 0 → CRC-only word; discard it, no beat.
  - last = 1 on the beat where rem − n = 2, i.e. the payload is exhausted.
  - rem ← rem − 4 if rem > 4, else 0.
  - rem reaches 0 → pkt_done_o, return to HEADER.
- CRC-only trailing word occurs when WC mod 4 ∈ {0, 3}, and also when WC = 0.
- WC = 0 long packet: header word, then one CRC word. No payload beat is emitted, only pkt_done_o.
- CRC bytes are not checked.
- enable_i deasserted: forces HEADER and rem = 0 at the next edge. A beat already registered still completes.
- Gaps with valid_i = 0: state, rem and outputs hold. Strobes return low after their one cycle.

## Timing
- All outputs are registered. Latency is 1 cycle from the clk_i edge sampling valid_i to the corresponding output.
- pkt_done_o asserts in the same cycle as the final payload beat (payload_last_o). If the packet ends on a CRC-only word, pkt_done_o asserts in the cycle after that word is sampled.
- Back-to-back packets are allowed: a header word may arrive the cycle after a packet's final word.
- Reset values:
  - All strobes, valid, last and ecc_err_o = 0.
  - payload_data_o = 0, payload_be_o = 0, payload_dt_o = 0, payload_vc_o = 0, short_data_o = 0.
  - State = HEADER, rem = 0.
- Reset asserted mid-packet: everything clears asynchronously. Words after release are parsed as a new header.
- payload_dt_o and payload_vc_o are stable from the first beat through the last beat of a packet.

## Test plan
- Frame Start (short packet): header DI = 0x00, WC = 0x0001, correct ECC → frame_start_o pulse, short_data_o = 0x0001, pkt_done_o pulse, no payload beat.
- Long packet, RAW10 (DT 0x2B), VC 1, WC = 5:
  - Input: header, word 0x44332211, word 0x00CRCR55.
  - Required: beat 0x44332211 with be = 0xF; then beat [7:0] = 0x55 with be = 0x1 and last = 1.
  - pkt_done_o asserts with the last beat; payload_dt_o = 0x2B, payload_vc_o = 1.
- Long packet, WC = 4:
  - Input: three words.
  - Required: exactly one beat (be = 0xF, last = 1); the CRC word is dropped; pkt_done_o asserts the cycle after the CRC word is sampled.
- ECC error: header with bit 10 flipped → ecc_err_o and pkt_done_o pulse together, no strobes. The next valid header is parsed normally.
- Gaps and back-to-back:
  - Stimulus: WC = 8 packet with valid_i low 3 cycles between payload words, followed immediately by a Line End short packet.
  - Required: beats are unchanged; line_end_o pulses.
- Reset and enable:
  - rst_n_i low in the middle of a WC = 16 payload → all outputs 0 immediately. The next word after release is treated as a header.
  - enable_i low mid-packet gives the same parser restart.
